// File: rtl/pbypass_ctrl.sv
// ============================================================================
// pbypass_ctrl
// ----------------------------------------------------------------------------
// Upstream controller for the programmable delay by-pass counter.
// It accepts by-pass instructions (a delay count V) over a valid/ready
// handshake and loads them into the counter. It holds the datapath stall
// until the counter's registered TERMINATE arrives. Then it pulses DONE and
// releases the stall. The counter shows a stale TERMINATE in the cycle after
// a load, so the FSM passes through a GUARD state that ignores it.
//
// Configuration macro:
//   PBYPASS_QUEUE_EN  - when defined, a 2-entry instruction FIFO sits in front
//                       of the FSM. Entry 0 is the by-pass in flight and entry
//                       1 is the next one queued. Back-to-back by-passes run
//                       with no IDLE gap. When undefined, a single holding
//                       register is used and instructions are only accepted
//                       in IDLE.
//
// Ports:
//   CLK          in   clock, rising edge
//   RESET        in   synchronous reset, active-low
//   INSTR_VALID  in   by-pass instruction present
//   INSTR_COUNT  in   requested delay count V
//   INSTR_READY  out  instruction accepted when VALID & READY at an edge
//   ABORT        in   cancel the current and all queued by-passes
//   LOAD_COUNT   out  to counter: load COUNT_VALUE this edge
//   COUNT_VALUE  out  to counter: delay value being loaded (held otherwise)
//   TERMINATE    in   from counter: registered (count == 0)
//   STALL        out  hold the datapath pipeline
//   DONE         out  one-cycle pulse per completed by-pass
//   BUSY         out  state != IDLE
// ============================================================================
module pbypass_ctrl #(
    parameter int COUNT_W = 8
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               INSTR_VALID,
    input  logic [COUNT_W-1:0] INSTR_COUNT,
    output logic               INSTR_READY,
    input  logic               ABORT,
    output logic               LOAD_COUNT,
    output logic [COUNT_W-1:0] COUNT_VALUE,
    input  logic               TERMINATE,
    output logic               STALL,
    output logic               DONE,
    output logic               BUSY
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_GUARD,
        S_WAIT
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [COUNT_W-1:0] r_count_value;
    logic               r_done;

    logic               w_accept;     // instruction handshake completes this edge
    logic               w_finish;     // by-pass completes normally this edge
    logic               w_ready_base; // readiness before the ABORT/RESET gating
    logic               w_idle_start; // IDLE has work to start
    logic               w_wait_more;  // WAIT has another by-pass to chain into
    logic [COUNT_W-1:0] w_idle_value; // value loaded when leaving IDLE
    logic [COUNT_W-1:0] w_wait_value; // value loaded when chaining from WAIT
    logic [COUNT_W-1:0] w_load_value;

    assign w_accept = INSTR_VALID && INSTR_READY;
    // ABORT wins over TERMINATE arriving in the same cycle.
    assign w_finish = (r_state == S_WAIT) && TERMINATE && !ABORT;

`ifdef PBYPASS_QUEUE_EN
    logic [COUNT_W-1:0] r_fifo [2];
    logic [1:0]         r_fifo_cnt;

    assign w_ready_base = (r_fifo_cnt != 2'd2);
    assign w_idle_start = w_accept || (r_fifo_cnt != 2'd0);
    // Entry 0 is the by-pass finishing now. Chain if entry 1 exists, or if a
    // new instruction arrives as entry 0 pops.
    assign w_wait_more  = (r_fifo_cnt == 2'd2) || w_accept;
    assign w_idle_value = (r_fifo_cnt != 2'd0) ? r_fifo[0] : INSTR_COUNT;
    assign w_wait_value = (r_fifo_cnt == 2'd2) ? r_fifo[1] : INSTR_COUNT;

    // NOTE: FIFO storage has no reset. Only the occupancy count is reset, and
    // no entry is read before it has been written.
    always_ff @(posedge CLK) begin
        if (!RESET || ABORT) begin
            r_fifo_cnt <= 2'd0;
        end else begin
            case ({w_accept, w_finish})
                2'b10: begin
                    r_fifo[r_fifo_cnt[0]] <= INSTR_COUNT;
                    r_fifo_cnt            <= r_fifo_cnt + 2'd1;
                end
                2'b01: begin
                    r_fifo[0]  <= r_fifo[1];
                    r_fifo_cnt <= r_fifo_cnt - 2'd1;
                end
                2'b11: begin
                    // Pop and push together: the occupancy is unchanged.
                    if (r_fifo_cnt == 2'd1) begin
                        r_fifo[0] <= INSTR_COUNT;
                    end else begin
                        r_fifo[0] <= r_fifo[1];
                        r_fifo[1] <= INSTR_COUNT;
                    end
                end
                default: ;
            endcase
        end
    end
`else
    assign w_ready_base = (r_state == S_IDLE);
    assign w_idle_start = w_accept;
    assign w_wait_more  = 1'b0;
    assign w_idle_value = INSTR_COUNT;
    assign w_wait_value = INSTR_COUNT;
`endif

    assign w_load_value = (r_state == S_WAIT) ? w_wait_value : w_idle_value;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only. Every
    // register then samples pre-edge values, whatever the process order.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    // NOTE: the default assignment at the top keeps this block free of
    // inferred latches on paths that do not set a value.
    always_comb begin
        w_state_next = r_state;
        if (ABORT && (r_state != S_IDLE)) begin
            w_state_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (w_idle_start && !ABORT) w_state_next = S_LOAD;
                S_LOAD:  w_state_next = S_GUARD;
                // TERMINATE here still reflects the count before the load.
                S_GUARD: w_state_next = S_WAIT;
                S_WAIT:  if (TERMINATE) w_state_next = w_wait_more ? S_LOAD : S_IDLE;
                default: w_state_next = S_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers: loaded value (held outside LOAD) and DONE pulse
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            r_count_value <= '0;
            r_done        <= 1'b0;
        end else begin
            if (w_state_next == S_LOAD) begin
                r_count_value <= w_load_value;
            end
            r_done <= w_finish;
        end
    end

    // ------------------------------------------------------------------
    // FSM: outputs. Only INSTR_READY depends on inputs.
    // ------------------------------------------------------------------
    always_comb begin
        INSTR_READY = RESET && w_ready_base && !ABORT;
        LOAD_COUNT  = (r_state == S_LOAD);
        STALL       = (r_state != S_IDLE);
        BUSY        = (r_state != S_IDLE);
        COUNT_VALUE = r_count_value;
        DONE        = r_done;
    end

endmodule

// File: tb/tb_pbypass_ctrl.sv
// ============================================================================
// tb_pbypass_ctrl
// ----------------------------------------------------------------------------
// Directed testbench for pbypass_ctrl. It includes a behavioural model of the
// by-pass counter on LOAD_COUNT/COUNT_VALUE/TERMINATE.
// A negedge monitor records stall run lengths, DONE pulses and the values
// loaded. The main initial block drives inputs and checks outputs at
// negedge + 1.
// ============================================================================
module tb_pbypass_ctrl;

    localparam int COUNT_W = 8;
`ifdef PBYPASS_QUEUE_EN
    localparam logic QUEUE_EN = 1'b1;
`else
    localparam logic QUEUE_EN = 1'b0;
`endif

    logic               CLK;
    logic               RESET;
    logic               INSTR_VALID;
    logic [COUNT_W-1:0] INSTR_COUNT;
    logic               INSTR_READY;
    logic               ABORT;
    logic               LOAD_COUNT;
    logic [COUNT_W-1:0] COUNT_VALUE;
    logic               TERMINATE;
    logic               STALL;
    logic               DONE;
    logic               BUSY;

    pbypass_ctrl #(.COUNT_W(COUNT_W)) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .INSTR_VALID (INSTR_VALID),
        .INSTR_COUNT (INSTR_COUNT),
        .INSTR_READY (INSTR_READY),
        .ABORT       (ABORT),
        .LOAD_COUNT  (LOAD_COUNT),
        .COUNT_VALUE (COUNT_VALUE),
        .TERMINATE   (TERMINATE),
        .STALL       (STALL),
        .DONE        (DONE),
        .BUSY        (BUSY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // By-pass counter: loads on LOAD_COUNT, counts down to 0 and holds there.
    // TERMINATE is the registered (count == 0) of the previous cycle.
    logic [COUNT_W-1:0] cnt_q;
    logic               term_q;
    always @(posedge CLK) begin
        if (!RESET) begin
            cnt_q  <= '0;
            term_q <= 1'b0;
        end else begin
            if (LOAD_COUNT) cnt_q <= COUNT_VALUE;
            else if (cnt_q != 0) cnt_q <= cnt_q - 1'b1;
            term_q <= (cnt_q == 0);
        end
    end
    assign TERMINATE = term_q;

    // Monitor
    int               cur_run  = 0;
    int               last_run = 0;
    int               done_cnt = 0;
    int               busy_mis = 0;
    logic [COUNT_W-1:0] load_vals [$];

    always @(negedge CLK) begin
        if (STALL === 1'b1) begin
            cur_run <= cur_run + 1;
        end else if (cur_run != 0) begin
            last_run <= cur_run;
            cur_run  <= 0;
        end
        if (DONE === 1'b1) done_cnt <= done_cnt + 1;
        if (LOAD_COUNT === 1'b1) load_vals.push_back(COUNT_VALUE);
        if (BUSY !== STALL) busy_mis <= busy_mis + 1;
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        @(negedge CLK);
        #1;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n;
        n = 0;
        while (STALL === 1'b1 && n < budget) begin
            tick();
            n++;
        end
        check(tag, {31'd0, STALL}, 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_stall"}, {31'd0, STALL},       32'd0);
        check({tag, "_busy"},  {31'd0, BUSY},        32'd0);
        check({tag, "_load"},  {31'd0, LOAD_COUNT},  32'd0);
        check({tag, "_cval"},  {24'd0, COUNT_VALUE}, 32'd0);
        check({tag, "_done"},  {31'd0, DONE},        32'd0);
        check({tag, "_ready"}, {31'd0, INSTR_READY}, 32'd1);
    endtask

    // Watchdog: bounds the whole run.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    int d0;
    int l0;
    int n;
    int ready_hi;

    initial begin
        RESET       = 1'b0;
        INSTR_VALID = 1'b0;
        INSTR_COUNT = '0;
        ABORT       = 1'b0;
        tick();
        tick();

        // ---------------- Reset state ----------------
        check("rst_ready_low", {31'd0, INSTR_READY}, 32'd0);
        RESET = 1'b1;
        #1;
        check_reset_outputs("rst");

        // ---------------- 1: V=5 ----------------
        d0 = done_cnt;
        l0 = load_vals.size();
        INSTR_VALID = 1'b1;
        INSTR_COUNT = 8'd5;
        #1;
        check("t1_ready", {31'd0, INSTR_READY}, 32'd1);
        tick();
        INSTR_VALID = 1'b0;
        #1;
        check("t1_load",  {31'd0, LOAD_COUNT},  32'd1);
        check("t1_cval",  {24'd0, COUNT_VALUE}, 32'd5);
        check("t1_stall", {31'd0, STALL},       32'd1);
        check("t1_ready_busy", {31'd0, INSTR_READY}, {31'd0, QUEUE_EN});
        wait_idle("t1_idle", 300);
        check("t1_stall_len", last_run, 32'd8);
        check("t1_done_now", {31'd0, DONE}, 32'd1);
        check("t1_done_cnt", done_cnt - d0, 32'd1);
        check("t1_loads", load_vals.size() - l0, 32'd1);
        check("t1_load_val", {24'd0, load_vals[l0]}, 32'd5);
        tick();
        check("t1_done_drop", {31'd0, DONE}, 32'd0);
        check("t1_cval_held", {24'd0, COUNT_VALUE}, 32'd5);

        // ---------------- 2: V=0 with TERMINATE already 1 ----------------
        RESET = 1'b0;
        tick();
        RESET = 1'b1;
        #1;
        check_reset_outputs("t2_rst");
        tick();
        tick();
        d0 = done_cnt;
        l0 = load_vals.size();
        INSTR_VALID = 1'b1;
        INSTR_COUNT = 8'd0;
        tick();
        INSTR_VALID = 1'b0;
        check("t2_load", {31'd0, LOAD_COUNT}, 32'd1);
        wait_idle("t2_idle", 50);
        check("t2_stall_len", last_run, 32'd3);
        check("t2_done_cnt", done_cnt - d0, 32'd1);
        check("t2_load_val", {24'd0, load_vals[l0]}, 32'd0);
        tick();

        // ---------------- 3: V=10, ABORT on the 4th WAIT cycle ----------------
        d0 = done_cnt;
        l0 = load_vals.size();
        INSTR_VALID = 1'b1;
        INSTR_COUNT = 8'd10;
        tick();
        INSTR_VALID = 1'b0;
        repeat (5) tick();
        check("t3_stall_pre", {31'd0, STALL}, 32'd1);
        ABORT = 1'b1;
        #1;
        check("t3_ready_abort", {31'd0, INSTR_READY}, 32'd0);
        tick();
        ABORT = 1'b0;
        #1;
        check("t3_stall_drop", {31'd0, STALL},       32'd0);
        check("t3_busy_drop",  {31'd0, BUSY},        32'd0);
        check("t3_no_done",    {31'd0, DONE},        32'd0);
        check("t3_ready",      {31'd0, INSTR_READY}, 32'd1);
        check("t3_stall_len",  last_run,             32'd6);
        repeat (15) tick();
        check("t3_quiet_stall", cur_run, 32'd0);
        check("t3_quiet_done",  done_cnt - d0, 32'd0);
        check("t3_quiet_loads", load_vals.size() - l0, 32'd1);

        // ---------------- 4: V=7, reset mid-WAIT, then V=1 ----------------
        d0 = done_cnt;
        INSTR_VALID = 1'b1;
        INSTR_COUNT = 8'd7;
        tick();
        INSTR_VALID = 1'b0;
        repeat (3) tick();
        check("t4_stall_pre", {31'd0, STALL}, 32'd1);
        RESET = 1'b0;
        #1;
        check("t4_ready_rst", {31'd0, INSTR_READY}, 32'd0);
        tick();
        RESET = 1'b1;
        #1;
        check_reset_outputs("t4_rst");
        check("t4_stall_len", last_run, 32'd4);
        check("t4_no_done", done_cnt - d0, 32'd0);
        l0 = load_vals.size();
        INSTR_VALID = 1'b1;
        INSTR_COUNT = 8'd1;
        tick();
        INSTR_VALID = 1'b0;
        check("t4_cval", {24'd0, COUNT_VALUE}, 32'd1);
        wait_idle("t4_idle", 50);
        check("t4_stall_len2", last_run, 32'd4);
        check("t4_done_cnt", done_cnt - d0, 32'd1);
        tick();

`ifdef PBYPASS_QUEUE_EN
        // ---------------- 6: queued V=2,0,4 ----------------
        d0 = done_cnt;
        l0 = load_vals.size();
        INSTR_VALID = 1'b1;
        INSTR_COUNT = 8'd2;
        #1;
        check("t6_ready0", {31'd0, INSTR_READY}, 32'd1);
        tick();
        INSTR_COUNT = 8'd0;
        #1;
        check("t6_ready1", {31'd0, INSTR_READY}, 32'd1);
        tick();
        INSTR_COUNT = 8'd4;
        #1;
        check("t6_ready_full", {31'd0, INSTR_READY}, 32'd0);
        n = 0;
        while (INSTR_READY !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        check("t6_held_cycles", n, 32'd4);
        check("t6_chain_load", {31'd0, LOAD_COUNT}, 32'd1);
        tick();
        INSTR_VALID = 1'b0;
        wait_idle("t6_idle", 300);
        check("t6_stall_len", last_run, 32'd15);
        check("t6_done_cnt", done_cnt - d0, 32'd3);
        check("t6_loads", load_vals.size() - l0, 32'd3);
        check("t6_load_a", {24'd0, load_vals[l0]},     32'd2);
        check("t6_load_b", {24'd0, load_vals[l0 + 1]}, 32'd0);
        check("t6_load_c", {24'd0, load_vals[l0 + 2]}, 32'd4);
`else
        // ---------------- 5: hold V=3 while BUSY ----------------
        l0 = load_vals.size();
        INSTR_VALID = 1'b1;
        INSTR_COUNT = 8'd2;
        tick();
        INSTR_COUNT = 8'd3;
        ready_hi = 0;
        n = 0;
        while (STALL === 1'b1 && n < 50) begin
            if (INSTR_READY !== 1'b0) ready_hi++;
            tick();
            n++;
        end
        check("t5_ready_busy", ready_hi, 32'd0);
        check("t5_stall_len1", last_run, 32'd5);
        check("t5_done1", {31'd0, DONE}, 32'd1);
        check("t5_ready_idle", {31'd0, INSTR_READY}, 32'd1);
        tick();
        INSTR_VALID = 1'b0;
        check("t5_load", {31'd0, LOAD_COUNT}, 32'd1);
        check("t5_cval", {24'd0, COUNT_VALUE}, 32'd3);
        wait_idle("t5_idle", 50);
        check("t5_stall_len2", last_run, 32'd6);
        check("t5_load_val", {24'd0, load_vals[l0 + 1]}, 32'd3);
`endif

        tick();
        check("busy_mirrors_stall", busy_mis, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
